// File: rtl/mplier_16x16_if.sv
// Operand/result bundle for mplier_16x16: the testbench or the parent datapath drives
// the master side, and the multiplier takes the slave side.
interface mplier_16x16_if;
   logic        in_valid;
   logic [15:0] a;
   logic [15:0] b;
   logic [31:0] product;
   logic        out_valid;

   modport master (output in_valid, a, b, input product, out_valid);
   modport slave  (input in_valid, a, b, output product, out_valid);
endinterface

// File: rtl/mplier_16x16.sv
// Two-stage signed 16x16 multiplier: radix-4 Booth rows, CSA tree, registered carry-propagate add.
// Define MPLIER_16X16_UNSIGNED_EN to treat a/b as unsigned (adds a ninth Booth row).
module mplier_16x16 (
   input  logic          clk,
   input  logic          rst_n,
   mplier_16x16_if.slave bus
);

`ifdef MPLIER_16X16_UNSIGNED_EN
   localparam int NPP = 9;
`else
   localparam int NPP = 8;
`endif
   // Sum of -2^(17+2i) over all rows; the ninth row's term lies above bit 31, so both builds match
   localparam logic [31:0] SIGN_CORR_C = 32'h5556_0000;

   logic [16:0] a_ext_s;
   logic [18:0] b_ext_s;
   logic [31:0] rows_s [0:10];
   logic [31:0] neg_row_s;
   logic [2:0]  dig_s;
   logic [31:0] l1_s [0:7];
   logic [31:0] l2_s [0:5];
   logic [31:0] l3_s [0:3];
   logic [31:0] l4_s [0:2];
   logic [63:0] t_s;
   logic [31:0] sum_s;
   logic [31:0] carry_s;
   logic [31:0] sum_r;
   logic [31:0] carry_r;
   logic        valid_r;
   logic [31:0] product_r;
   logic        out_valid_r;

   // Booth group {b[2i+1], b[2i], b[2i-1]} -> {neg, one, two}
   function automatic logic [2:0] booth_digit(input logic [2:0] grp);
      logic [2:0] d;
      case (grp)
         3'b000:  d = 3'b000;
         3'b001:  d = 3'b010;
         3'b010:  d = 3'b010;
         3'b011:  d = 3'b001;
         3'b100:  d = 3'b101;
         3'b101:  d = 3'b110;
         3'b110:  d = 3'b110;
         3'b111:  d = 3'b100;
         default: d = 3'b000;
      endcase
      return d;
   endfunction

   // 18-bit one's-complement partial product with its sign bit inverted
   function automatic logic [17:0] pp_row(input logic [2:0] dig, input logic [16:0] ax);
      logic [17:0] sel;
      logic [17:0] x;
      case (dig[1:0])
         2'b10:   sel = {ax[16], ax};
         2'b01:   sel = {ax, 1'b0};
         default: sel = 18'h0;
      endcase
      x = sel ^ {18{dig[2]}};
      return {~x[17], x[16:0]};
   endfunction

   // 3:2 compressor on whole vectors: returns {carry, sum}
   function automatic logic [63:0] csa(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      logic [31:0] maj;
      maj = (x & y) | (x & z) | (y & z);
      return {maj[30:0], 1'b0, x ^ y ^ z};
   endfunction

`ifdef MPLIER_16X16_UNSIGNED_EN
   assign a_ext_s = {1'b0, bus.a};
   assign b_ext_s = {2'b00, bus.b, 1'b0};
`else
   assign a_ext_s = {bus.a[15], bus.a};
   assign b_ext_s = {{2{bus.b[15]}}, bus.b, 1'b0};
`endif

   // Partial-product rows plus the negate-increment row and the sign correction
   always_comb begin
      for (int i = 0; i < 11; i++) begin
         rows_s[i] = 32'h0;
      end
      neg_row_s = 32'h0;
      dig_s     = 3'b000;
      for (int i = 0; i < NPP; i++) begin
         dig_s            = booth_digit(b_ext_s[2*i +: 3]);
         rows_s[i]        = {14'h0, pp_row(dig_s, a_ext_s)} << (2*i);
         neg_row_s[2*i]   = dig_s[2];
      end
      rows_s[NPP]   = neg_row_s;
      rows_s[NPP+1] = SIGN_CORR_C;
   end

   // Carry-save reduction 11 -> 8 -> 6 -> 4 -> 3 -> 2
   always_comb begin
      t_s = 64'h0;
      for (int g = 0; g < 3; g++) begin
         t_s           = csa(rows_s[3*g], rows_s[3*g+1], rows_s[3*g+2]);
         l1_s[2*g]     = t_s[31:0];
         l1_s[2*g+1]   = t_s[63:32];
      end
      l1_s[6] = rows_s[9];
      l1_s[7] = rows_s[10];
      for (int g = 0; g < 2; g++) begin
         t_s           = csa(l1_s[3*g], l1_s[3*g+1], l1_s[3*g+2]);
         l2_s[2*g]     = t_s[31:0];
         l2_s[2*g+1]   = t_s[63:32];
      end
      l2_s[4] = l1_s[6];
      l2_s[5] = l1_s[7];
      for (int g = 0; g < 2; g++) begin
         t_s           = csa(l2_s[3*g], l2_s[3*g+1], l2_s[3*g+2]);
         l3_s[2*g]     = t_s[31:0];
         l3_s[2*g+1]   = t_s[63:32];
      end
      t_s     = csa(l3_s[0], l3_s[1], l3_s[2]);
      l4_s[0] = t_s[31:0];
      l4_s[1] = t_s[63:32];
      l4_s[2] = l3_s[3];
      t_s     = csa(l4_s[0], l4_s[1], l4_s[2]);
      sum_s   = t_s[31:0];
      carry_s = t_s[63:32];
   end

   // Stage 1: register the carry-save pair and the valid bit every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r   <= 32'h0;
         carry_r <= 32'h0;
         valid_r <= 1'b0;
      end else begin
         sum_r   <= sum_s;
         carry_r <= carry_s;
         valid_r <= bus.in_valid;
      end
   end

   // Stage 2: final carry-propagate add
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product_r   <= 32'h0;
         out_valid_r <= 1'b0;
      end else begin
         product_r   <= sum_r + carry_r;
         out_valid_r <= valid_r;
      end
   end

   assign bus.product   = product_r;
   assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mplier_16x16.sv
// Self-checking bench for mplier_16x16: reset behaviour, corner products, random
// bubbly streams and a sampled sweep against a plain-arithmetic reference product.
module tb_mplier_16x16;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   mplier_16x16_if bus();

   mplier_16x16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
`ifdef MPLIER_16X16_UNSIGNED_EN
      longint ux;
      longint uy;
      ux = longint'(x);
      uy = longint'(y);
      return 32'(ux * uy);
`else
      int sx;
      int sy;
      sx = int'($signed(x));
      sy = int'($signed(y));
      return 32'(sx * sy);
`endif
   endfunction

   task automatic test_reset();
      logic [31:0] exp_p;
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.a = 16'($urandom);
         bus.b = 16'($urandom);
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
         end
         n_checks++;
         if (bus.product !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_product: got %h expected 00000000", bus.product);
         end
      end
      // release, then push one op and kill it with an async reset between edges
      rst_n        = 1'b1;
      bus.a        = 16'h1234;
      bus.b        = 16'hFF00;
      exp_p        = ref_mul(16'h1234, 16'hFF00);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.product !== exp_p) begin
         n_fail++;
         $display("FAIL first_after_release: got v=%b p=%h expected v=1 p=%h",
                  bus.out_valid, bus.product, exp_p);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.product !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: got v=%b p=%h expected v=0 p=00000000",
                  bus.out_valid, bus.product);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [31:0] exp_p [4];
      logic        exp_v [4];
      exp_v = '{1'b0, 1'b0, 1'b1, 1'b0};
      exp_p = '{32'h0, 32'h0, 32'hFFFF_FFF1, 32'h0};
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== exp_v[j]) begin
            n_fail++;
            $display("FAIL single_valid[%0d]: got %b expected %b", j, bus.out_valid, exp_v[j]);
         end
         if (exp_v[j]) begin
            n_checks++;
            if (bus.product !== exp_p[j]) begin
               n_fail++;
               $display("FAIL single_product: got %h expected %h", bus.product, exp_p[j]);
            end
         end
         bus.in_valid = (j == 0);
         bus.a        = 16'd3;
         bus.b        = 16'hFFFB;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_corners();
      logic [15:0] a_t [5];
      logic [15:0] b_t [5];
      logic [31:0] p_t [5];
`ifdef MPLIER_16X16_UNSIGNED_EN
      a_t = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000};
      b_t = '{16'hFFFF, 16'h0002, 16'h0001, 16'h8000, 16'hFFFF};
      p_t = '{32'hFFFE_0001, 32'h0001_0000, 32'h0000_FFFF, 32'h4000_0000, 32'h0};
`else
      a_t = '{16'h8000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
      b_t = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h8000};
      p_t = '{32'h4000_0000, 32'hC000_8000, 32'h3FFF_0001, 32'h0000_0001, 32'h0};
`endif
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== (j >= 2 && j < 7)) begin
            n_fail++;
            $display("FAIL corner_valid[%0d]: got %b", j, bus.out_valid);
         end
         if (j >= 2 && j < 7) begin
            n_checks++;
            if (bus.product !== p_t[j-2]) begin
               n_fail++;
               $display("FAIL corner_product[%0d]: got %h expected %h", j-2, bus.product, p_t[j-2]);
            end
         end
         bus.in_valid = (j < 5);
         bus.a        = (j < 5) ? a_t[j] : 16'h0;
         bus.b        = (j < 5) ? b_t[j] : 16'h0;
      end
      bus.in_valid = 1'b0;
   endtask

   // Stream with random bubbles; expectations ride a two-deep queue as issued
   task automatic test_stream(input int n_ops, input bit bubbles, input bit sweep_corners);
      logic        v_q [$];
      logic [31:0] p_q [$];
      logic [15:0] corner [16];
      logic        ev;
      logic [31:0] ep;
      int          n_in;
      int          n_out;
      int          n_grid;
      corner = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'h7FFF,
                 16'h7FFE, 16'h8000, 16'h8001, 16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00, 16'h4000};
      n_in   = 0;
      n_out  = 0;
      n_grid = sweep_corners ? 256 : 0;
      v_q    = '{1'b0, 1'b0};
      p_q    = '{32'h0, 32'h0};
      for (int j = 0; j < n_grid + n_ops + 2; j++) begin
         @(negedge clk);
         ev = v_q.pop_front();
         ep = p_q.pop_front();
         n_checks++;
         if (bus.out_valid !== ev) begin
            n_fail++;
            $display("FAIL stream_valid[%0d]: got %b expected %b", j, bus.out_valid, ev);
         end
         if (ev) begin
            n_checks++;
            if (bus.product !== ep) begin
               n_fail++;
               $display("FAIL stream_product[%0d]: got %h expected %h", j, bus.product, ep);
            end
         end
         if (bus.out_valid === 1'b1) n_out++;
         if (j < n_grid) begin
            bus.in_valid = 1'b1;
            bus.a        = corner[j / 16];
            bus.b        = corner[j % 16];
         end else if (j < n_grid + n_ops) begin
            bus.in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.a        = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 15)] : 16'($urandom);
            bus.b        = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 15)] : 16'($urandom);
         end else begin
            bus.in_valid = 1'b0;
         end
         if (bus.in_valid) n_in++;
         v_q.push_back(bus.in_valid);
         p_q.push_back(ref_mul(bus.a, bus.b));
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (n_out != n_in) begin
         n_fail++;
         $display("FAIL pulse_count: got %0d outputs expected %0d", n_out, n_in);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.a        = 16'h0;
      bus.b        = 16'h0;
      test_reset();
`ifndef MPLIER_16X16_UNSIGNED_EN
      test_single();
`endif
      test_corners();
      test_stream(1000, 1'b1, 1'b0);
      test_stream(16384, 1'b0, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
